mips_regfile_sb: RTL
====================

# mips_regfile_sb

Parametrised general-purpose register file with an integrated pending-write scoreboard and a sequential clear engine. It is intended for the pipelined MIPS core. It provides two combinational read ports and one write-back port, with register 0 hard-wired to zero. It tracks in-flight destination registers so that decode can stall on RAW/WAW hazards, and it can zero the whole file on request without a reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W (derived localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_we  in  1  write-back enable.
- wb_addr  in  ADDR_W  write-back register index.
- wb_data  in  DATA_W  write-back data.
- rd_addr1  in  ADDR_W  read port 1 index.
- rd_data1  out  DATA_W  read port 1 data.
- rd_addr2  in  ADDR_W  read port 2 index.
- rd_data2  out  DATA_W  read port 2 data.
- iss_valid  in  1  decode presents an instruction for issue.
- iss_dst  in  ADDR_W  destination index of issuing instruction; 0 means no destination.
- iss_src1  in  ADDR_W  source 1 index; 0 means unused.
- iss_src2  in  ADDR_W  source 2 index; 0 means unused.
- stall  out  1  issue blocked this cycle; combinational.
- clr_req  in  1  request to zero all registers; single-cycle pulse or level.
- clr_busy  out  1  clear engine active.

## Operation
- Reset:
  - All registers are 0.
  - All pend bits are 0.
  - The FSM is in IDLE; the clear counter is 0.
  - Outputs: clr_busy = 0; stall = 0; rd_data reflects zeros.
- Reads:
  - rd_dataN = 0 when rd_addrN == 0.
  - Otherwise rd_dataN = reg[rd_addrN], combinationally.
- Write:
  - When wb_we && wb_addr != 0 in IDLE, reg[wb_addr] <= wb_data.
  - Writes to index 0 are discarded.
- Scoreboard, one pend bit per register; pend[0] is constantly 0:
  - Hazard: stall = iss_valid && (pend[iss_src1] || pend[iss_src2] || pend[iss_dst]), with index 0 never contributing.
  - Set: when iss_valid && !stall && iss_dst != 0, pend[iss_dst] <= 1.
  - Clear: when wb_we && wb_addr != 0, pend[wb_addr] <= 0.
  - Set and clear of the same index in the same cycle: set wins.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req = 1 is sampled; the counter loads 1 and all pend bits are cleared.
  - In CLEAR, each cycle writes reg[counter] <= 0 and increments the counter. After writing index NREGS-1 the FSM returns to IDLE.
  - In CLEAR, wb_we is ignored (no register or pend update).
  - In CLEAR, stall = iss_valid, so no issue is accepted.
  - clr_req while in CLEAR is ignored and does not restart the sequence.
  - rst mid-clear returns the block to the reset state immediately.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility: the value written at edge N is readable after edge N. A same-cycle read returns the old value unless RF_BYPASS_EN is defined.
- Scoreboard: a pend bit set at edge N causes stall from cycle N+1 onward.
- Clear: clr_busy is high for exactly NREGS-1 cycles. It rises after the edge that samples clr_req and falls after the edge that writes index NREGS-1.
- stall is a pure function of the current state and the iss_* inputs.

## Configuration
- RF_BYPASS_EN defined:
  - When wb_we && wb_addr == rd_addrN && wb_addr != 0 && FSM in IDLE, rd_dataN = wb_data.
  - A source whose pend bit is being cleared by a write-back in the same cycle does not cause stall.
  - A destination in the same situation still follows the normal rule (pend cleared, then set wins).
- RF_BYPASS_EN undefined:
  - No forwarding.
  - stall uses the registered pend bits only, so a source being written this cycle stalls for one more cycle.

## Structure
- Shared package mips_rf_pkg holds:
  - Default DATA_W/ADDR_W constants.
  - The FSM state enum (RF_IDLE, RF_CLEAR).
- Sub-module rf_scoreboard holds the pend vector, the set/clear priority logic and the stall computation. It is parameterised by ADDR_W.
- The top level holds the storage array, read muxes/bypass and the clear FSM.

## Test plan
- Reset then reads: rst pulse, then read addr 5 and 31 -> rd_data1 = rd_data2 = 0; clr_busy = 0.
- Write/read and r0: write 0xDEADBEEF to r7, then 0x1234 to r0. Next cycle read r7 and r0 -> 0xDEADBEEF and 0.
- Scoreboard RAW:
  - Issue dst = 3 with srcs 0, then issue src1 = 3 -> stall = 1.
  - Write-back r3 -> the next cycle stall = 0.
  - With RF_BYPASS_EN, stall = 0 in the write-back cycle and rd_data1 = wb_data.
- Simultaneous set/clear: write-back r4 and issue dst = 4 in the same cycle -> pend[4] = 1 afterwards, so a src = 4 issue stalls.
- Clear sequence: fill r1..r31 with nonzero values and pulse clr_req.
  - clr_busy is high for 31 cycles.
  - wb_we during clear is ignored.
  - Afterwards all reads return 0 and all pend bits are 0.
- Reset mid-clear: assert rst during cycle 10 of CLEAR -> clr_busy = 0 immediately; all registers read 0; the FSM is in IDLE.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared constants and FSM state type for the MIPS register file slice.
// Default widths and the clear-engine state encoding.
package mips_rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

endpackage

// File: rtl/mips_regfile_sb_scoreboard.sv
// Pending-write scoreboard: one pend bit per register, RAW/WAW stall.
// RF_BYPASS_EN lets a source being written back this cycle skip the stall.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] iss_src1,
  input  logic [ADDR_W-1:0] iss_src2,
  input  logic              wb_fire,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              flush,
  input  logic              block,
  output logic              stall
);

  localparam int NREGS = 2**ADDR_W;

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic             src1_hz;
  logic             src2_hz;
  logic             dst_hz;
  logic             accept;

  always_comb begin
    src1_hz = (iss_src1 != '0) && pend[iss_src1];
    src2_hz = (iss_src2 != '0) && pend[iss_src2];
`ifdef RF_BYPASS_EN
    if (wb_fire && (wb_addr == iss_src1)) src1_hz = 1'b0;
    if (wb_fire && (wb_addr == iss_src2)) src2_hz = 1'b0;
`endif
    dst_hz = (iss_dst != '0) && pend[iss_dst];
    stall  = iss_valid &&
             (block || src1_hz || src2_hz || dst_hz);
    accept = iss_valid && !stall && (iss_dst != '0);
  end

  // Issue set is applied after write-back clear so set wins.
  always_comb begin
    pend_nxt = pend;
    if (wb_fire) pend_nxt[wb_addr] = 1'b0;
    if (accept)  pend_nxt[iss_dst] = 1'b1;
    if (flush)   pend_nxt = '0;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

endmodule

// File: rtl/mips_regfile_sb.sv
// Register file with scoreboard and sequential clear engine.
// Optional same-cycle write forwarding: define RF_BYPASS_EN.
module mips_regfile_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] iss_src1,
  input  logic [ADDR_W-1:0] iss_src2,
  output logic              stall,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int NREGS = 2**ADDR_W;

  rf_state_t         state;
  rf_state_t         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic              idle;
  logic              wb_fire;
  logic              clr_start;

  assign idle     = (state == RF_IDLE);
  assign wb_fire  = idle && wb_we && (wb_addr != '0);
  assign clr_busy = !idle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RF_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_start = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          clr_start = 1'b1;
        end
      end
      RF_CLEAR: begin
        if (&cnt) state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  // Index 0 is never stored, so the sweep starts at 1 and wraps to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cnt <= '0;
    else if (clr_start) cnt <= ADDR_W'(1);
    else if (!idle)     cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (!idle) begin
      regs[cnt] <= '0;
    end else if (wb_fire) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
`ifdef RF_BYPASS_EN
    if (wb_fire && (wb_addr == rd_addr1)) rd_data1 = wb_data;
`endif
  end

  always_comb begin
    rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
`ifdef RF_BYPASS_EN
    if (wb_fire && (wb_addr == rd_addr2)) rd_data2 = wb_data;
`endif
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_valid(iss_valid),
    .iss_dst  (iss_dst),
    .iss_src1 (iss_src1),
    .iss_src2 (iss_src2),
    .wb_fire  (wb_fire),
    .wb_addr  (wb_addr),
    .flush    (clr_start),
    .block    (!idle),
    .stall    (stall)
  );

endmodule
